uart_msg_enc: RTL and testbench
===============================

Name: uart_msg_enc

Overview:
- Parametrised ASCII message encoder between the UART control logic and the UART transmitter.
- Converts one-hot text events and multi-digit hex values into an ASCII byte stream.
- Buffers the bytes in an internal FIFO and drains it to the TX with a valid/ready handshake.
- Replaces single-character, fire-and-forget encoding: a value of NUM_DIGITS nibbles is emitted MSB-first, and nothing is lost while the TX is busy.

Parameters:
- NUM_DIGITS, 2, hex digits per numeric request (1..8); NUM_VAL width = 4*NUM_DIGITS.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2.

Ports:
- CLK_100M  in  1  clock
- SYS_RST  in  1  reset, asynchronous, active-high
- TEXT_REQ  in  8  one-hot text event pulses: [7]'O' 0x4F, [6]'K' 0x4B, [5]'F' 0x46, [4]'A' 0x41, [3]'I' 0x49, [2]'L' 0x4C, [1]LF 0x0A, [0]'>' 0x3E
- NUM_REQ  in  1  numeric request pulse
- NUM_VAL  in  4*NUM_DIGITS  value to print in hex
- REQ_BUSY  out  1  encoder not accepting requests
- TX_VALID  out  1  TX_DATA holds a byte
- TX_DATA  out  8  ASCII byte
- TX_READY  in  1  transmitter accepts the byte
- OVERFLOW  out  1  sticky: request dropped
- CLR_OVF  in  1  synchronous clear of OVERFLOW

Behaviour:
- Reset values: state IDLE, FIFO empty, REQ_BUSY=0, TX_VALID=0, TX_DATA=0x00, OVERFLOW=0. Asserting SYS_RST mid-message discards the message and the FIFO contents.
- States: IDLE, EMIT.
- IDLE, request sampled: any TEXT_REQ bit or NUM_REQ.
  - Priority TEXT_REQ[7] > ... > TEXT_REQ[0] > NUM_REQ; only the winner is captured.
  - Any other request asserted in the same cycle is dropped and sets OVERFLOW.
  - Text: load one character, char_cnt=1.
  - Numeric: latch NUM_VAL, char_cnt=NUM_DIGITS (plus 2 when the optional feature is enabled).
  - Next state EMIT.
- EMIT:
  - Each cycle the FIFO is not full: push the current char and decrement char_cnt. Numeric chars go MSB nibble first; the shift register shifts left 4 bits per push.
  - FIFO full: stall with no push and no state change.
  - After the last push: return to IDLE. IDLE accepts a new request in the following cycle.
- Nibble mapping: 0-9 -> 0x30-0x39; A-F -> 0x41-0x46.
- REQ_BUSY = (state==EMIT). Any TEXT_REQ or NUM_REQ asserted while REQ_BUSY=1 is dropped and sets OVERFLOW.
- OVERFLOW: set has priority over a simultaneous CLR_OVF.
- FIFO: first-word-fall-through, registered output.
  - TX_VALID=1 iff FIFO not empty; TX_DATA = head entry.
  - Pop on TX_VALID & TX_READY.
  - TX_DATA holds stable while TX_VALID=1 and TX_READY=0.
  - Simultaneous push and pop when full: the pop frees the entry, so the push is accepted. Simultaneous push and pop when empty: the pushed byte becomes visible the next cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from the MSB/wrap comparison. Wrap-around is transparent.
- Latency: with an empty FIFO and TX_READY=1, a request in cycle N gives its first char pushed at N+1 and TX_VALID=1 with that char at N+2. Throughput is then 1 byte/cycle.
- When the FIFO is empty, TX_DATA is 0x00.

Optional Feature:
- Macro: UART_MSG_ENC_CRLF_EN.
- Defined: each numeric message is followed by CR 0x0D then LF 0x0A; char_cnt = NUM_DIGITS+2. Text messages are unchanged.
- Undefined: a numeric message is exactly NUM_DIGITS characters and no CR/LF logic is synthesised.

Test Plan:
- Reset release, TX_READY=1, pulse TEXT_REQ=8'h80 -> REQ_BUSY=1 for 1 cycle; TX_VALID=1 with TX_DATA=0x4F two cycles after the request, for one cycle; OVERFLOW=0.
- NUM_DIGITS=2, NUM_REQ with NUM_VAL=8'hA7, TX_READY=1 -> bytes 0x41 then 0x37 on consecutive cycles; with CRLF_EN, additionally 0x0D, 0x0A.
- TX_READY=0 while 3 numeric requests of 0x3C, 0x5E, 0xF0 are issued back to back with FIFO_DEPTH=8 -> FIFO reaches 6 entries and TX_DATA stays 0x33. Then TX_READY=1 -> stream 0x33,0x43,0x35,0x45,0x46,0x30.
- TX_READY=0, 5 numeric requests of 2 digits -> FIFO full after the 4th; EMIT stalls with REQ_BUSY=1 and a 6th request sets OVERFLOW. Raising TX_READY drains 10 correct bytes in order; then CLR_OVF -> OVERFLOW=0.
- Same cycle TEXT_REQ=8'h03 and NUM_REQ=1 -> only 0x0A is emitted; OVERFLOW=1.
- SYS_RST asserted during EMIT with 3 bytes queued -> TX_VALID=0 immediately (asynchronous) and no stale bytes after release; the next TEXT_REQ[0] yields 0x3E.

Source files
------------

// File: rtl/uart_msg_enc_if.sv
// rtl/uart_msg_enc_if.sv - request, TX handshake and overflow signals of the ASCII message encoder
interface uart_msg_enc_if #(
    parameter int NUM_DIGITS = 2
);
    logic [7:0]              TEXT_REQ;
    logic                    NUM_REQ;
    logic [4*NUM_DIGITS-1:0] NUM_VAL;
    logic                    REQ_BUSY;
    logic                    TX_VALID;
    logic [7:0]              TX_DATA;
    logic                    TX_READY;
    logic                    OVERFLOW;
    logic                    CLR_OVF;

    modport master (
        output TEXT_REQ, NUM_REQ, NUM_VAL, TX_READY, CLR_OVF,
        input  REQ_BUSY, TX_VALID, TX_DATA, OVERFLOW
    );

    modport slave (
        input  TEXT_REQ, NUM_REQ, NUM_VAL, TX_READY, CLR_OVF,
        output REQ_BUSY, TX_VALID, TX_DATA, OVERFLOW
    );
endinterface

// File: rtl/uart_msg_enc.sv
// rtl/uart_msg_enc.sv - text/hex event to ASCII byte encoder with FWFT output FIFO (option: UART_MSG_ENC_CRLF_EN)
module uart_msg_enc #(
    parameter int NUM_DIGITS = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          CLK_100M,
    input  logic          SYS_RST,
    uart_msg_enc_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int VW = 4 * NUM_DIGITS;
    localparam int CW = 4;
`ifdef UART_MSG_ENC_CRLF_EN
    localparam logic [CW-1:0] NUM_LEN = CW'(NUM_DIGITS + 2);
`else
    localparam logic [CW-1:0] NUM_LEN = CW'(NUM_DIGITS);
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state, state_nxt;
    logic            is_text;
    logic [7:0]      text_q;
    logic [VW-1:0]   shift_q;
    logic [CW-1:0]   char_cnt;
    logic [7:0]      cur_char;
    logic [7:0]      text_sel;
    logic            text_hit;
    logic [8:0]      req_vec;
    logic            any_req;
    logic            multi_req;
    logic            push;
    logic            pop;
    logic            req_busy;
    logic            overflow_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            fifo_empty, fifo_full;

    function automatic logic [7:0] text_char(input logic [2:0] idx);
        case (idx)
            3'd7:    text_char = 8'h4F;
            3'd6:    text_char = 8'h4B;
            3'd5:    text_char = 8'h46;
            3'd4:    text_char = 8'h41;
            3'd3:    text_char = 8'h49;
            3'd2:    text_char = 8'h4C;
            3'd1:    text_char = 8'h0A;
            default: text_char = 8'h3E;
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign req_vec   = {bus.TEXT_REQ, bus.NUM_REQ};
    assign any_req   = |req_vec;
    // more than one bit set means every loser of the priority pick is dropped
    assign multi_req = |(req_vec & (req_vec - 9'd1));
    assign text_hit  = |bus.TEXT_REQ;

    always_comb begin
        text_sel = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (bus.TEXT_REQ[i]) text_sel = text_char(3'(i));
        end
    end

    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (any_req) state_nxt = EMIT;
            EMIT: if (push && char_cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_busy = (state == EMIT);
        // a same-cycle pop frees a slot, so a full FIFO still takes the push
        push     = (state == EMIT) && (!fifo_full || pop);
        cur_char = is_text ? text_q : hex_char(shift_q[VW-1 -: 4]);
`ifdef UART_MSG_ENC_CRLF_EN
        if (!is_text && char_cnt == CW'(2)) cur_char = 8'h0D;
        if (!is_text && char_cnt == CW'(1)) cur_char = 8'h0A;
`endif
    end

    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            is_text  <= 1'b0;
            text_q   <= 8'h00;
            shift_q  <= '0;
            char_cnt <= '0;
        end else if (state == IDLE && any_req) begin
            if (text_hit) begin
                is_text  <= 1'b1;
                text_q   <= text_sel;
                char_cnt <= CW'(1);
            end else begin
                is_text  <= 1'b0;
                shift_q  <= bus.NUM_VAL;
                char_cnt <= NUM_LEN;
            end
        end else if (push) begin
            char_cnt <= char_cnt - CW'(1);
            if (!is_text) shift_q <= shift_q << 4;
        end
    end

    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST)
            overflow_q <= 1'b0;
        else if (any_req && (state == EMIT || multi_req))
            overflow_q <= 1'b1;
        else if (bus.CLR_OVF)
            overflow_q <= 1'b0;
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && bus.TX_READY;

    always_ff @(posedge CLK_100M) begin
        if (push) mem[wr_ptr[AW-1:0]] <= cur_char;
    end

    always_ff @(posedge CLK_100M or posedge SYS_RST) begin
        if (SYS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign bus.REQ_BUSY = req_busy;
    assign bus.OVERFLOW = overflow_q;
    assign bus.TX_VALID = !fifo_empty;
    assign bus.TX_DATA  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_uart_msg_enc.sv
// tb/tb_uart_msg_enc.sv - scoreboard bench for uart_msg_enc
module tb_uart_msg_enc;
    logic CLK_100M;
    logic SYS_RST;

    uart_msg_enc_if #(.NUM_DIGITS(2)) bus ();

    uart_msg_enc #(.NUM_DIGITS(2), .FIFO_DEPTH(8)) dut (
        .CLK_100M (CLK_100M),
        .SYS_RST  (SYS_RST),
        .bus      (bus.slave)
    );

`ifdef UART_MSG_ENC_CRLF_EN
    localparam int MSG_LEN = 4;
`else
    localparam int MSG_LEN = 2;
`endif
    localparam int N_FILL = 8 / MSG_LEN + 1;

    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        CLK_100M = 1'b0;
        forever #5 CLK_100M = ~CLK_100M;
    end

    always @(negedge CLK_100M) begin
        if (!SYS_RST && bus.TX_VALID && bus.TX_READY) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_byte: got 0x%02h, required no byte (nothing expected)", bus.TX_DATA);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.TX_DATA !== e) begin
                    n_fail++;
                    $display("FAIL tx_byte: got 0x%02h, required 0x%02h", bus.TX_DATA, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_100M);
        #1;
    endtask

    task automatic wait_not_busy(input string name);
        int cyc = 0;
        while (bus.REQ_BUSY === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        if (bus.REQ_BUSY !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: REQ_BUSY stuck at %b, required 0 within 200 cycles", name, bus.REQ_BUSY);
        end
    endtask

    task automatic drain(input string name);
        int cyc = 0;
        while ((exp_q.size() != 0 || bus.TX_VALID === 1'b1) && cyc < 300) begin
            tick();
            cyc++;
        end
        check({name, "_left"}, exp_q.size(), 0);
        check({name, "_valid"}, bus.TX_VALID, 1'b0);
    endtask

    task automatic issue_text(input logic [7:0] req, input logic [7:0] b);
        wait_not_busy("issue_text_wait");
        bus.TEXT_REQ = req;
        exp_q.push_back(b);
        tick();
        bus.TEXT_REQ = 8'h00;
    endtask

    task automatic issue_num(input logic [7:0] val, input logic [7:0] hi, input logic [7:0] lo);
        wait_not_busy("issue_num_wait");
        bus.NUM_VAL = val;
        bus.NUM_REQ = 1'b1;
        exp_q.push_back(hi);
        exp_q.push_back(lo);
`ifdef UART_MSG_ENC_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
        tick();
        bus.NUM_REQ = 1'b0;
    endtask

    logic [7:0] fill_val [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    logic [7:0] fill_hi  [5] = '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39};
    logic [7:0] fill_lo  [5] = '{8'h32, 8'h34, 8'h36, 8'h38, 8'h41};

    initial begin
        SYS_RST      = 1'b1;
        bus.TEXT_REQ = 8'h00;
        bus.NUM_REQ  = 1'b0;
        bus.NUM_VAL  = 8'h00;
        bus.TX_READY = 1'b0;
        bus.CLR_OVF  = 1'b0;
        tick();
        tick();
        check("rst_tx_valid", bus.TX_VALID, 1'b0);
        check("rst_tx_data", bus.TX_DATA, 8'h00);
        check("rst_req_busy", bus.REQ_BUSY, 1'b0);
        check("rst_overflow", bus.OVERFLOW, 1'b0);
        SYS_RST = 1'b0;
        tick();

        // single text char, latency and busy width
        bus.TX_READY = 1'b1;
        bus.TEXT_REQ = 8'h80;
        exp_q.push_back(8'h4F);
        tick();
        bus.TEXT_REQ = 8'h00;
        check("t1_busy_n1", bus.REQ_BUSY, 1'b1);
        check("t1_valid_n1", bus.TX_VALID, 1'b0);
        tick();
        check("t1_busy_n2", bus.REQ_BUSY, 1'b0);
        check("t1_valid_n2", bus.TX_VALID, 1'b1);
        check("t1_data_n2", bus.TX_DATA, 8'h4F);
        tick();
        check("t1_valid_n3", bus.TX_VALID, 1'b0);
        check("t1_overflow", bus.OVERFLOW, 1'b0);

        // one numeric message
        issue_num(8'hA7, 8'h41, 8'h37);
        drain("t2_drain");

        // three messages queued with the TX stalled
        bus.TX_READY = 1'b0;
        issue_num(8'h3C, 8'h33, 8'h43);
        issue_num(8'h5E, 8'h35, 8'h45);
        issue_num(8'hF0, 8'h46, 8'h30);
        repeat (4) tick();
        for (int k = 0; k < 3; k++) begin
            check("t3_hold_valid", bus.TX_VALID, 1'b1);
            check("t3_hold_data", bus.TX_DATA, 8'h33);
            tick();
        end
`ifndef UART_MSG_ENC_CRLF_EN
        check("t3_idle", bus.REQ_BUSY, 1'b0);
`endif
        bus.TX_READY = 1'b1;
        drain("t3_drain");

        // fill the FIFO, stall EMIT, then drop a request while busy
        bus.TX_READY = 1'b0;
        for (int k = 0; k < N_FILL; k++) issue_num(fill_val[k], fill_hi[k], fill_lo[k]);
        repeat (4) tick();
        check("t4_stall_busy", bus.REQ_BUSY, 1'b1);
        check("t4_no_ovf_yet", bus.OVERFLOW, 1'b0);
        bus.NUM_VAL = 8'hEE;
        bus.NUM_REQ = 1'b1;
        tick();
        bus.NUM_REQ = 1'b0;
        check("t4_ovf_set", bus.OVERFLOW, 1'b1);
        check("t4_still_busy", bus.REQ_BUSY, 1'b1);
        bus.TX_READY = 1'b1;
        drain("t4_drain");
        check("t4_ovf_sticky", bus.OVERFLOW, 1'b1);
        bus.CLR_OVF = 1'b1;
        tick();
        bus.CLR_OVF = 1'b0;
        check("t4_ovf_clr", bus.OVERFLOW, 1'b0);

        // simultaneous requests, set beats clear
        wait_not_busy("t5_wait");
        bus.TEXT_REQ = 8'h03;
        bus.NUM_REQ  = 1'b1;
        bus.CLR_OVF  = 1'b1;
        exp_q.push_back(8'h0A);
        tick();
        bus.TEXT_REQ = 8'h00;
        bus.NUM_REQ  = 1'b0;
        bus.CLR_OVF  = 1'b0;
        check("t5_ovf_set", bus.OVERFLOW, 1'b1);
        drain("t5_drain");
        bus.CLR_OVF = 1'b1;
        tick();
        bus.CLR_OVF = 1'b0;
        check("t5_ovf_clr", bus.OVERFLOW, 1'b0);

        // asynchronous reset mid-message
        bus.TX_READY = 1'b0;
        issue_text(8'h80, 8'h4F);
        issue_text(8'h40, 8'h4B);
        issue_num(8'h55, 8'h35, 8'h35);
        tick();
        check("t6_pre_valid", bus.TX_VALID, 1'b1);
        check("t6_pre_busy", bus.REQ_BUSY, 1'b1);
        #2;
        SYS_RST = 1'b1;
        #1;
        check("t6_rst_valid", bus.TX_VALID, 1'b0);
        check("t6_rst_data", bus.TX_DATA, 8'h00);
        check("t6_rst_busy", bus.REQ_BUSY, 1'b0);
        exp_q.delete();
        tick();
        tick();
        SYS_RST = 1'b0;
        bus.TX_READY = 1'b1;
        tick();
        check("t6_post_valid", bus.TX_VALID, 1'b0);
        issue_text(8'h01, 8'h3E);
        drain("t6_drain");
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
